ifetch_queue: RTL and testbench
===============================

// Module: ifetch_queue
// PURPOSE
//   Instruction fetch stage feeding the core decoder. Drives the RAM's 32-bit combinational
//   instruction read port (addr2/out2), captures one instruction per cycle into a prefetch FIFO,
//   and presents {pc, instr} to the decoder over a valid/ready handshake.
//   A redirect (branch/jump) flushes the queue and restarts fetch at a new PC.
// PARAMETERS
//   ALEN      64  address width; fetch PC width
//   ILEN      32  instruction width; matches RAM port-2 data width
//   DEPTH     4   FIFO entries; power of two, >= 2
//   RESET_PC  4   fetch PC loaded on reset
// PORTS
//   clk             in   1                   rising-edge clock
//   rst             in   1                   synchronous, active-high reset
//   fetch_addr      out  ALEN                to RAM addr2; equals fetch_pc
//   fetch_data      in   ILEN                from RAM out2; combinational word at fetch_addr
//   fetch_req       out  1                   1 when this cycle's fetch_data is pushed
//   redirect_valid  in   1                   flush queue and restart at redirect_pc
//   redirect_pc     in   ALEN                new fetch PC; bits [1:0] forced to 0
//   out_valid       out  1                   head entry valid (count != 0)
//   out_ready       in   1                   decoder accepts head entry
//   out_instr       out  ILEN                head instruction
//   out_pc          out  ALEN                PC of head instruction
//   count           out  $clog2(DEPTH+1)     current occupancy
// BEHAVIOUR
//   - Reset: fetch_pc=RESET_PC, count=0, rd/wr ptrs=0, out_valid=0, fetch_req=0; out_instr/out_pc
//     don't-care while out_valid=0. rst has priority over all other inputs.
//   - fetch_addr = fetch_pc, combinational from register; RAM returns fetch_data same cycle.
//   - pop  = out_valid & out_ready.
//   - push = !redirect_valid & (count < DEPTH | pop). fetch_req = push.
//   - On push: write {fetch_pc, fetch_data} at wr_ptr; wr_ptr++; fetch_pc <= fetch_pc + 4.
//   - On pop: rd_ptr++. count <= count + push - pop; push&pop when full keeps count=DEPTH.
//   - Pointers are log2(DEPTH) bits and wrap naturally; fetch_pc wraps modulo 2^ALEN.
//   - Latency: instruction fetched in cycle N is visible at out_* in cycle N+1 (registered FIFO).
//     After rst or redirect, first out_valid is 2 cycles after the rst/redirect cycle.
//   - Redirect (highest priority after rst): count<=0, ptrs<=0,
//     fetch_pc <= {redirect_pc[ALEN-1:2],2'b00}, no push.
//     A pop in the same cycle is legal; the decoder owns that instruction. All others discarded.
//   - Full (count==DEPTH) and no pop: no push, fetch_pc holds, fetch_req=0.
//   - Empty: out_valid=0; out_ready ignored.
//   - out_instr/out_pc stable while out_valid & !out_ready (no redirect).
//   - Storage: DEPTH x (ALEN+ILEN) flops; no RAM write port usage.
// TESTING
//   1 rst 1 cycle, out_ready=1, RAM word@0x4=0x0A025000 -> cycle 2: out_valid=1,
//     out_pc=0x4, out_instr=0x0A025000; then out_pc 0x8,0xC,0x10... one per cycle.
//   2 out_ready=0 from reset -> count 1,2,3,4 then holds 4; fetch_pc=0x14, fetch_req=0;
//     head stays pc=0x4.
//   3 full, then out_ready=1 one cycle -> pop pc=0x4 and push pc=0x14 same cycle;
//     count stays 4, next head pc=0x8.
//   4 count=3, redirect_valid=1, redirect_pc=0x103 with out_ready=1 -> pc=0x4 consumed;
//     next cycle count=0, fetch_addr=0x100; cycle after, out_pc=0x100.
//   5 redirect_pc=0xFFFF_FFFF_FFFF_FFFC, stall out_ready -> queued PCs 0xFFFF_FFFF_FFFF_FFFC,
//     0x0, 0x4, 0x8 (wrap).
//   6 rst asserted with count=2 and redirect_valid=1 -> next cycle count=0, out_valid=0,
//     fetch_addr=RESET_PC.

Source files
------------

// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - instruction fetch stage with prefetch FIFO and redirect flush
//
// Purpose:
//   Drives the RAM's combinational instruction read port, captures one word per cycle
//   into a DEPTH-entry prefetch FIFO, and presents {pc, instr} to the decoder over a
//   valid/ready handshake. A redirect flushes the queue and restarts fetch at a new PC.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   fetch_addr / fetch_data  RAM port-2 address out / combinational data in
//   fetch_req                high when this cycle's fetch_data is pushed
//   redirect_valid/_pc       flush and restart fetch at redirect_pc (word aligned)
//   out_valid/ready          decoder handshake for the head entry
//   out_instr / out_pc       head entry contents
//   count                    current occupancy
module ifetch_queue #(
    parameter int unsigned           ALEN     = 64,
    parameter int unsigned           ILEN     = 32,
    parameter int unsigned           DEPTH    = 4,
    parameter logic [ALEN-1:0]       RESET_PC = ALEN'(4)
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic [ALEN-1:0]              fetch_addr,
    input  logic [ILEN-1:0]              fetch_data,
    output logic                         fetch_req,
    input  logic                         redirect_valid,
    input  logic [ALEN-1:0]              redirect_pc,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ILEN-1:0]              out_instr,
    output logic [ALEN-1:0]              out_pc,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [ALEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   count_q,    count_d;
    logic [PW-1:0]   rd_ptr_q,   rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q,   wr_ptr_d;
    logic [ALEN-1:0] pc_mem_q    [DEPTH];
    logic [ALEN-1:0] pc_mem_d    [DEPTH];
    logic [ILEN-1:0] instr_mem_q [DEPTH];
    logic [ILEN-1:0] instr_mem_d [DEPTH];

    logic pop;
    logic push;

    assign fetch_addr = fetch_pc_q;
    assign count      = count_q;
    assign out_valid  = (count_q != '0);
    assign out_pc     = pc_mem_q[rd_ptr_q];
    assign out_instr  = instr_mem_q[rd_ptr_q];

    assign pop       = out_valid & out_ready;
    // A pop frees a slot this cycle, so a full queue can still accept a fetch.
    assign push      = !rst && !redirect_valid && ((count_q < CW'(DEPTH)) || pop);
    assign fetch_req = push;

    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        count_d     = count_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        pc_mem_d    = pc_mem_q;
        instr_mem_d = instr_mem_q;

        if (redirect_valid) begin
            // Any same-cycle pop already handed its entry to the decoder; the rest is dropped.
            fetch_pc_d = redirect_pc & ~ALEN'(3);
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end else begin
            if (push) begin
                pc_mem_d[wr_ptr_q]    = fetch_pc_q;
                instr_mem_d[wr_ptr_q] = fetch_data;
                wr_ptr_d              = wr_ptr_q + PW'(1);
                fetch_pc_d            = fetch_pc_q + ALEN'(4);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // Storage needs no reset: entries are only observed while out_valid is high.
    always_ff @(posedge clk) begin
        pc_mem_q    <= pc_mem_d;
        instr_mem_q <= instr_mem_d;
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// tb/tb_ifetch_queue.sv - self-checking bench for ifetch_queue
module tb_ifetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] fetch_addr;
    logic [31:0] fetch_data;
    logic        fetch_req;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic [2:0]  count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ifetch_queue #(.ALEN(64), .ILEN(32), .DEPTH(4), .RESET_PC(64'h4)) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_addr     (fetch_addr),
        .fetch_data     (fetch_data),
        .fetch_req      (fetch_req),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .count          (count)
    );

    function automatic logic [31:0] ram_word(input logic [63:0] a);
        if (a == 64'h4) return 32'h0A02_5000;
        return a[31:0] ^ 32'hA5A5_0000;
    endfunction

    assign fetch_data = ram_word(fetch_addr);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard model
    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        sb[$];
    logic [63:0] m_pc;
    int          m_count;
    bit          m_init = 0;

    // Apply one cycle of inputs, check against the model mid-cycle, then advance the model.
    task automatic step(input logic r, input logic rv, input logic [63:0] rpc, input logic rdy);
        bit m_pop, m_push;
        rst            = r;
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
        @(negedge clk);
        if (m_init) begin
            m_pop  = (m_count != 0) && rdy;
            m_push = !r && !rv && ((m_count < 4) || m_pop);
            chk("sb_fetch_addr", fetch_addr, m_pc);
            chk("sb_fetch_req", 64'(fetch_req), 64'(m_push));
            chk("sb_count", 64'(count), 64'(m_count));
            chk("sb_out_valid", 64'(out_valid), 64'(m_count != 0));
            if (m_count != 0) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 64'(sb.size()), 64'd1);
                end else begin
                    chk("sb_out_pc", out_pc, sb[0].pc);
                    chk("sb_out_instr", 64'(out_instr), 64'(sb[0].instr));
                    if (m_pop) void'(sb.pop_front());
                end
            end
            if (r) begin
                m_pc = 64'h4; m_count = 0; sb.delete();
            end else if (rv) begin
                m_pc = rpc & ~64'h3; m_count = 0; sb.delete();
            end else begin
                if (m_push) begin
                    sb.push_back('{pc: m_pc, instr: ram_word(m_pc)});
                    m_pc = m_pc + 64'h4;
                end
                m_count = m_count + int'(m_push) - int'(m_pop);
            end
        end else if (r) begin
            m_pc = 64'h4; m_count = 0; sb.delete(); m_init = 1;
        end
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        r;
        logic        rv;
        logic [63:0] rpc;
        logic        rdy;
        bit          chk_en;
        int          e_count;
        logic        e_valid;
        logic [63:0] e_addr;
        logic        e_req;
        logic [63:0] e_pc;
    } vec_t;

    vec_t tbl[$];

    task automatic row(input logic r, input logic rv, input logic [63:0] rpc, input logic rdy,
                       input bit ce, input int c, input logic v, input logic [63:0] a,
                       input logic q, input logic [63:0] p);
        tbl.push_back('{r, rv, rpc, rdy, ce, c, v, a, q, p});
    endtask

    localparam logic [63:0] TOP = 64'hFFFF_FFFF_FFFF_FFFC;

    initial begin
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
        #1;

        // reset, then stream with decoder always ready
        row(1,0,0,1, 0, 0,0,0,0,0);
        row(0,0,0,1, 1, 0,0,64'h4,1,0);
        row(0,0,0,1, 1, 1,1,64'h8,1,64'h4);
        row(0,0,0,1, 1, 1,1,64'hC,1,64'h8);
        row(0,0,0,1, 1, 1,1,64'h10,1,64'hC);
        // fill to DEPTH with decoder stalled
        row(1,0,0,0, 0, 0,0,0,0,0);
        row(0,0,0,0, 1, 0,0,64'h4,1,0);
        row(0,0,0,0, 1, 1,1,64'h8,1,64'h4);
        row(0,0,0,0, 1, 2,1,64'hC,1,64'h4);
        row(0,0,0,0, 1, 3,1,64'h10,1,64'h4);
        row(0,0,0,0, 1, 4,1,64'h14,0,64'h4);
        row(0,0,0,0, 1, 4,1,64'h14,0,64'h4);
        // pop and push together while full
        row(0,0,0,1, 1, 4,1,64'h14,1,64'h4);
        row(0,0,0,0, 1, 4,1,64'h18,0,64'h8);
        // redirect with count=3 and a same-cycle pop
        row(1,0,0,0, 0, 0,0,0,0,0);
        row(0,0,0,0, 1, 0,0,64'h4,1,0);
        row(0,0,0,0, 1, 1,1,64'h8,1,64'h4);
        row(0,0,0,0, 1, 2,1,64'hC,1,64'h4);
        row(0,1,64'h103,1, 1, 3,1,64'h10,0,64'h4);
        row(0,0,0,1, 1, 0,0,64'h100,1,0);
        row(0,0,0,1, 1, 1,1,64'h104,1,64'h100);
        // redirect near the top of the address space, PCs wrap
        row(0,1,TOP,0, 1, 1,1,64'h108,0,64'h104);
        row(0,0,0,0, 1, 0,0,TOP,1,0);
        row(0,0,0,0, 1, 1,1,64'h0,1,TOP);
        row(0,0,0,0, 1, 2,1,64'h4,1,TOP);
        row(0,0,0,0, 1, 3,1,64'h8,1,TOP);
        row(0,0,0,0, 1, 4,1,64'hC,0,TOP);
        row(0,0,0,1, 1, 4,1,64'hC,1,TOP);
        row(0,0,0,1, 1, 4,1,64'h10,1,64'h0);
        row(0,0,0,1, 1, 4,1,64'h14,1,64'h4);
        row(0,0,0,1, 1, 4,1,64'h18,1,64'h8);
        // reset wins over a simultaneous redirect
        row(0,1,64'h200,0, 1, 4,1,64'h1C,0,64'hC);
        row(0,0,0,0, 1, 0,0,64'h200,1,0);
        row(0,0,0,0, 1, 1,1,64'h204,1,64'h200);
        row(1,1,64'h300,0, 1, 2,1,64'h208,0,64'h200);
        row(0,0,0,1, 1, 0,0,64'h4,1,0);

        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].r; redirect_valid = tbl[i].rv;
            redirect_pc = tbl[i].rpc; out_ready = tbl[i].rdy;
            #2;
            if (tbl[i].chk_en) begin
                chk($sformatf("t%0d_count", i), 64'(count), 64'(tbl[i].e_count));
                chk($sformatf("t%0d_valid", i), 64'(out_valid), 64'(tbl[i].e_valid));
                chk($sformatf("t%0d_addr", i), fetch_addr, tbl[i].e_addr);
                chk($sformatf("t%0d_req", i), 64'(fetch_req), 64'(tbl[i].e_req));
                if (tbl[i].e_valid) begin
                    chk($sformatf("t%0d_pc", i), out_pc, tbl[i].e_pc);
                    chk($sformatf("t%0d_instr", i), 64'(out_instr), 64'(ram_word(tbl[i].e_pc)));
                end
            end
            step(tbl[i].r, tbl[i].rv, tbl[i].rpc, tbl[i].rdy);
        end

        // Randomised traffic against the scoreboard: stalls, redirects, occasional reset.
        for (int i = 0; i < 400; i++) begin
            logic        r, rv, rdy;
            logic [63:0] rpc;
            r   = ($urandom_range(0, 63) == 0);
            rv  = ($urandom_range(0, 9) == 0);
            rdy = ($urandom_range(0, 2) != 0);
            rpc = {$urandom(), $urandom()};
            if ($urandom_range(0, 3) == 0) rpc = TOP - 64'(($urandom_range(0, 3)) * 4) + 64'($urandom_range(0, 3));
            step(r, rv, rpc, rdy);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
